// File: rtl/arf_multiport_if.sv
// Port bundle for the architectural register file: clear handshake, read ports and retire write ports.
// The core side (rename/recovery, ROB retire) drives through master; the register file uses slave.
interface arf_multiport_if #(
    parameter int AR_SIZE = 6,
    parameter int DATA_W  = 32,
    parameter int NUM_RD  = 4,
    parameter int NUM_WR  = 2
);
    logic                       clear_req;
    logic                       ready;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*AR_SIZE-1:0]  rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_WR-1:0]          wr_en;
    logic [NUM_WR*AR_SIZE-1:0]  wr_addr;
    logic [NUM_WR*DATA_W-1:0]   wr_data;

    modport master (
        output clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  ready, rd_data, rd_valid
    );

    modport slave (
        input  clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output ready, rd_data, rd_valid
    );
endinterface

// File: rtl/arf_multiport.sv
// Clocked multi-port architectural register file with write-first bypass and a self-clearing sweep.
// The array carries no flop reset; a CLEAR sweep zeroes one entry per cycle before ports go live.
module arf_multiport #(
    parameter int AR_SIZE  = 6,
    parameter int AR_ARRAY = 64,
    parameter int DATA_W   = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_WR   = 2
) (
    input  logic             clk,
    input  logic             rstn,
    arf_multiport_if.slave   bus
);
    typedef enum logic {CLEAR, READY} state_t;

    state_t                          state, state_nxt;
    logic [AR_SIZE-1:0]              clr_ptr, clr_ptr_nxt;
    logic [DATA_W-1:0]               mem [AR_ARRAY];
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_next_p0;
    logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_p1;
    logic [NUM_RD-1:0]               vld_p1;
    logic                            live;

    // x0 is hardwired to zero and addresses past the array are not backed by storage.
    function automatic logic addr_ok(input logic [AR_SIZE-1:0] a);
        return (a != '0) && (int'(a) < AR_ARRAY);
    endfunction

    assign live = (state == READY) && !bus.clear_req;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            CLEAR: begin
                clr_ptr_nxt = clr_ptr + AR_SIZE'(1);
                if (clr_ptr == AR_SIZE'(AR_ARRAY - 1)) begin
                    state_nxt   = READY;
                    clr_ptr_nxt = '0;
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    // Ascending port order makes the highest-index writer the last assignment, so it wins.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (!bus.clear_req) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && addr_ok(bus.wr_addr[j*AR_SIZE +: AR_SIZE]))
                        mem[bus.wr_addr[j*AR_SIZE +: AR_SIZE]] <= bus.wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // p0: array lookup, then same-cycle retire writes override it (write-first).
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_next_p0[i] = addr_ok(bus.rd_addr[i*AR_SIZE +: AR_SIZE])
                          ? mem[bus.rd_addr[i*AR_SIZE +: AR_SIZE]] : '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && addr_ok(bus.wr_addr[j*AR_SIZE +: AR_SIZE]) &&
                    (bus.wr_addr[j*AR_SIZE +: AR_SIZE] == bus.rd_addr[i*AR_SIZE +: AR_SIZE]))
                    rd_next_p0[i] = bus.wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // p1: registered read data; disabled ports hold their last value.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1     <= '0;
            rd_data_p1 <= '0;
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                vld_p1[i] <= live && bus.rd_en[i];
                if (live && bus.rd_en[i])
                    rd_data_p1[i] <= rd_next_p0[i];
            end
        end
    end

    assign bus.ready    = (state == READY);
    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_valid = vld_p1;
endmodule

// File: tb/tb_arf_multiport.sv
// Directed bench for arf_multiport: vector table for port behaviour plus sequences for clear and reset.
// A second instance with a 40-entry array covers out-of-range addressing.
module tb_arf_multiport;
    localparam int AS = 6;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int NW = 2;
    localparam logic [31:0] DB = 32'hDEADBEEF;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    arf_multiport_if #(.AR_SIZE(AS), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) b ();
    arf_multiport_if #(.AR_SIZE(AS), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) s ();

    arf_multiport #(.AR_SIZE(AS), .AR_ARRAY(64), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (b.slave)
    );

    arf_multiport #(.AR_SIZE(AS), .AR_ARRAY(40), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) dut_s (
        .clk (clk),
        .rstn(rstn),
        .bus (s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       we;
        logic [5:0]       wa0, wa1;
        logic [31:0]      wd0, wd1;
        logic [3:0]       re;
        logic [3:0][5:0]  ra;
        logic [3:0]       ev;
        logic [3:0][31:0] ed;
    } vec_t;

    vec_t tv [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts edges until ready rises; also flags any rd_valid seen while sweeping with reads requested.
    task automatic count_ready(input string nm, input int exp);
        int  n;
        logic vseen;
        n     = 0;
        vseen = 1'b0;
        b.rd_en = 4'hF;
        while (!b.ready && n < 200) begin
            tick();
            n++;
            if (!b.ready && b.rd_valid != 4'h0) vseen = 1'b1;
        end
        chk(nm, 128'(n), 128'(exp));
        chk({nm, "_vld"}, 128'(vseen), 128'(1'b0));
        b.rd_en = 4'h0;
    endtask

    task automatic read_all_zero(input string nm);
        for (int c = 0; c < 16; c++) begin
            b.rd_en = 4'hF;
            for (int i = 0; i < NR; i++) b.rd_addr[i*AS +: AS] = 6'(c*4 + i);
            tick();
            chk({nm, "_vld"}, 128'(b.rd_valid), 128'(4'hF));
            chk({nm, "_data"}, 128'(b.rd_data), 128'(0));
        end
        b.rd_en = 4'h0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        b.clear_req = 1'b0; b.rd_en = '0; b.rd_addr = '0; b.wr_en = '0; b.wr_addr = '0; b.wr_data = '0;
        s.clear_req = 1'b0; s.rd_en = '0; s.rd_addr = '0; s.wr_en = '0; s.wr_addr = '0; s.wr_data = '0;

        tv[0] = '{2'b01, 6'd5,  6'd0,  DB,            32'h0,      4'b0000, {6'd0, 6'd0,  6'd0,  6'd0},
                  4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}};
        tv[1] = '{2'b00, 6'd0,  6'd0,  32'h0,         32'h0,      4'b1111, {6'd5, 6'd5,  6'd5,  6'd5},
                  4'b1111, {DB, DB, DB, DB}};
        tv[2] = '{2'b11, 6'd7,  6'd7,  32'h11,        32'h22,     4'b0101, {6'd0, 6'd7,  6'd0,  6'd5},
                  4'b0101, {DB, 32'h22, DB, DB}};
        tv[3] = '{2'b11, 6'd0,  6'd9,  32'hFFFF_FFFF, 32'hA5A5,   4'b1010, {6'd7, 6'd0,  6'd0,  6'd0},
                  4'b1010, {32'h22, 32'h22, 32'h0, DB}};
        tv[4] = '{2'b11, 6'd5,  6'd63, 32'h55,        32'h1234,   4'b1111, {6'd5, 6'd63, 6'd9,  6'd0},
                  4'b1111, {32'h55, 32'h1234, 32'hA5A5, 32'h0}};
        tv[5] = '{2'b00, 6'd0,  6'd0,  32'h0,         32'h0,      4'b0000, {6'd5, 6'd63, 6'd9,  6'd0},
                  4'b0000, {32'h55, 32'h1234, 32'hA5A5, 32'h0}};
        tv[6] = '{2'b11, 6'd10, 6'd10, 32'hAAAA,      32'hBBBB,   4'b0000, {6'd0, 6'd0,  6'd0,  6'd0},
                  4'b0000, {32'h55, 32'h1234, 32'hA5A5, 32'h0}};
        tv[7] = '{2'b11, 6'd11, 6'd11, 32'h2,         32'h1,      4'b0011, {6'd0, 6'd0,  6'd11, 6'd10},
                  4'b0011, {32'h55, 32'h1234, 32'h1, 32'hBBBB}};
        tv[8] = '{2'b00, 6'd0,  6'd0,  32'h0,         32'h0,      4'b1110, {6'd5, 6'd11, 6'd7,  6'd0},
                  4'b1110, {32'h55, 32'h1, 32'h22, 32'hBBBB}};

        // Reset and initial sweep
        repeat (3) tick();
        chk("rst_ready", 128'(b.ready), 128'(1'b0));
        chk("rst_vld", 128'(b.rd_valid), 128'(4'h0));
        chk("rst_data", 128'(b.rd_data), 128'(0));
        rstn = 1'b1;
        count_ready("clear_len", 64);
        chk("s_ready", 128'(s.ready), 128'(1'b1));
        read_all_zero("init_zero");

        // Vector table
        for (int k = 0; k < 9; k++) begin
            b.wr_en = tv[k].we;
            b.wr_addr = {tv[k].wa1, tv[k].wa0};
            b.wr_data = {tv[k].wd1, tv[k].wd0};
            b.rd_en = tv[k].re;
            b.rd_addr = tv[k].ra;
            tick();
            chk($sformatf("v%0d_vld", k), 128'(b.rd_valid), 128'(tv[k].ev));
            for (int i = 0; i < NR; i++)
                chk($sformatf("v%0d_p%0d", k, i), 128'(b.rd_data[i*DW +: DW]), 128'(tv[k].ed[i]));
        end
        b.wr_en = '0; b.rd_en = '0;

        // Out-of-range addressing on the 40-entry instance
        s.wr_en = 2'b11; s.wr_addr = {6'd39, 6'd50}; s.wr_data = {32'h39, 32'h77};
        tick();
        s.wr_en = 2'b01; s.wr_addr = {6'd0, 6'd45}; s.wr_data = {32'h0, 32'h45};
        s.rd_en = 4'b0111; s.rd_addr = {6'd0, 6'd45, 6'd39, 6'd50};
        tick();
        chk("oor_vld", 128'(s.rd_valid), 128'(4'b0111));
        chk("oor_data", 128'(s.rd_data[95:0]), 128'({32'h0, 32'h39, 32'h0}));
        s.wr_en = '0; s.rd_en = '0;

        // Fill the array, then clear_req together with a write that must be dropped
        for (int a = 1; a < 64; a += 2) begin
            b.wr_en = 2'b11;
            b.wr_addr = {6'(a + 1), 6'(a)};
            b.wr_data = {32'(32'h100 + a + 1), 32'(32'h100 + a)};
            tick();
        end
        b.wr_en = '0;
        b.rd_en = 4'b0011; b.rd_addr = {6'd0, 6'd0, 6'd62, 6'd3};
        tick();
        chk("fill_data", 128'(b.rd_data[63:0]), 128'({32'h13E, 32'h103}));
        b.clear_req = 1'b1;
        b.wr_en = 2'b01; b.wr_addr = {6'd0, 6'd3}; b.wr_data = {32'h0, 32'h99};
        b.rd_en = 4'b0001; b.rd_addr = {6'd0, 6'd0, 6'd0, 6'd3};
        tick();
        b.clear_req = 1'b0; b.wr_en = '0;
        chk("creq_ready", 128'(b.ready), 128'(1'b0));
        chk("creq_vld", 128'(b.rd_valid), 128'(4'h0));
        count_ready("creq_len", 64);
        read_all_zero("creq_zero");

        // Reset in the middle of a sweep restarts it
        b.clear_req = 1'b1;
        tick();
        b.clear_req = 1'b0;
        repeat (29) tick();
        rstn = 1'b0;
        tick();
        chk("mid_ready", 128'(b.ready), 128'(1'b0));
        chk("mid_data", 128'(b.rd_data), 128'(0));
        rstn = 1'b1;
        count_ready("mid_len", 64);

        // Hold behaviour with rd_en low
        b.wr_en = 2'b01; b.wr_addr = {6'd0, 6'd20}; b.wr_data = {32'h0, 32'h2020};
        tick();
        b.wr_en = '0;
        b.rd_en = 4'b0001; b.rd_addr = {6'd0, 6'd0, 6'd0, 6'd20};
        tick();
        chk("hold_first", 128'({b.rd_valid, b.rd_data[31:0]}), 128'({4'b0001, 32'h2020}));
        b.rd_en = 4'b0000; b.rd_addr = {6'd0, 6'd0, 6'd0, 6'd5};
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold_%0d", c), 128'({b.rd_valid, b.rd_data[31:0]}), 128'({4'b0000, 32'h2020}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/arf_multiport.md
# arf_multiport

Parametrised architectural register file for the RISC-V out-of-order core, holding committed register state at retirement. Successor to the two-read/two-write combinational ARF: clocked, with NUM_RD synchronous read ports, NUM_WR retire write ports, write-to-read bypass, deterministic same-address write priority, and a self-clearing sweep FSM instead of a flop-level reset of the array. It sits between the ROB retire stage (writes) and the rename/recovery logic (reads).

## Interface
- AR_SIZE, 6, architectural register address width
- AR_ARRAY, 64, number of entries; must be ≤ 2^AR_SIZE
- DATA_W, 32, register data width
- NUM_RD, 4, number of read ports
- NUM_WR, 2, number of retire write ports
- clk  in  1  clock, all state updates on the rising edge
- rstn  in  1  reset, synchronous, active-low
- clear_req  in  1  request a full re-clear of the array; sampled only in READY
- ready  out  1  array cleared and ports live
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AR_SIZE  port i at bits [i*AR_SIZE +: AR_SIZE]
- rd_data  out  NUM_RD*DATA_W  port i at bits [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  rd_data for port i is valid this cycle
- wr_en  in  NUM_WR  per-port retire write enable
- wr_addr  in  NUM_WR*AR_SIZE  port j at bits [j*AR_SIZE +: AR_SIZE]
- wr_data  in  NUM_WR*DATA_W  port j at bits [j*DATA_W +: DATA_W]

## Operation
- States: CLEAR, READY. Counter clr_ptr, width AR_SIZE.
- Reset: rstn low at an edge -> state CLEAR, clr_ptr=0, ready=0, rd_valid=0, rd_data=0. The array itself is not reset by rstn.
- CLEAR: each edge with rstn high writes 0 to entry clr_ptr and increments clr_ptr. The edge that clears entry AR_ARRAY-1 moves state to READY and sets ready=1. Reads and writes are ignored; rd_valid stays 0.
- READY + clear_req=1: next state CLEAR, clr_ptr=0, ready=0. Reads and writes presented in that cycle are dropped, so rd_valid is 0 on the next cycle.
- Write (READY, clear_req=0): for each j with wr_en[j]=1 and wr_addr[j]!=0, the entry is written at the edge.
  - Writes to address 0 are discarded.
  - Addresses ≥ AR_ARRAY are discarded.
  - If several ports write the same address in one cycle, the highest port index wins.
- Read (READY, clear_req=0): for each i with rd_en[i]=1, rd_data[i] is registered at the edge and rd_valid[i]=1 for the following cycle.
  - Address 0 returns 0.
  - Address ≥ AR_ARRAY returns 0, with rd_valid still set.
  - A same-cycle write to the same address is bypassed (write-first), with the highest-index write winning.
- rd_en[i]=0: rd_data[i] holds its previous value; rd_valid[i]=0 next cycle.
- All read ports are independent. Any number of ports may read the same address.

## Timing
- Read latency is 1 cycle: address at edge N, data and rd_valid after edge N.
- Write-to-read through the array: a write at edge N is visible to a read presented in cycle N+1 (the edge N+1 sample). A read presented in the same cycle as the write sees the new value through the bypass.
- Clear duration: ready rises after exactly AR_ARRAY consecutive edges with rstn high following the last rstn-low edge, i.e. 64 by default.
- rstn low mid-sweep restarts the sweep at clr_ptr=0. rstn low while READY drops ready on the next edge.
- clear_req is ignored while in CLEAR. It is a level signal: held high in READY it re-enters CLEAR once per completed sweep.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset/clear: hold rstn low 3 cycles, release -> ready=0 for 64 edges then 1. A read of every address returns 0 with rd_valid=1 one cycle after each request.
- Basic write/read: write x5=0xDEADBEEF on port 0 at edge N. Read x5 on all 4 ports at edge N+1 -> each port returns 0xDEADBEEF with rd_valid=1 at N+2.
- Bypass and priority: in one cycle, port 0 writes x7=0x11, port 1 writes x7=0x22, and read port 2 reads x7 -> 0x22 returned next cycle. A later read of x7 also returns 0x22.
- x0 and out-of-range: write x0=0xFFFF_FFFF, then read x0 -> 0. With AR_ARRAY=40 and AR_SIZE=6, write address 50 then read address 50 -> 0.
- clear_req: fill x1..x63 with nonzero data, pulse clear_req together with a write of x3=0x99 -> write dropped, ready low for 64 cycles, then all reads return 0.
- Reset mid-sweep: assert rstn low at sweep cycle 30, release -> ready rises exactly 64 edges after release. Check the holding behaviour: with rd_en=0, rd_data is unchanged and rd_valid=0.
